fetch_pq: RTL

- Parametrised instruction fetch unit for the pcpu core. It is the successor to the single-entry-prefetch fetch stage.
- Holds up to DEPTH sequentially prefetched instructions in a tagged queue, so a run of straight-line pc advances is served with zero hold cycles.
- Sits between the core pc/decode logic and the shared RAM arbiter port.
- Uses the same ram_read / ram_cack / ram_data_ready handshake as the rest of the core.

---
 rtl/fetch_pkg.sv | 22 ++
 rtl/fetch_tagq.sv | 63 ++++++
 rtl/fetch_pq.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared fetch definitions: FSM state encodings and memory-op opcode decode,
// also used by the decode stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DEMAND  = 2'd1,
    ST_PREF    = 2'd2,
    ST_DISCARD = 2'd3
  } fetch_state_t;

  localparam logic [7:0] OPC_MEM_A = 8'h02;
  localparam logic [7:0] OPC_MEM_B = 8'h03;
  localparam logic [7:0] OPC_MEM_C = 8'h05;
  localparam logic [7:0] OPC_MEM_D = 8'h06;

  function automatic logic is_memop(input logic [7:0] opc);
    return (opc == OPC_MEM_A) || (opc == OPC_MEM_B) ||
           (opc == OPC_MEM_C) || (opc == OPC_MEM_D);
  endfunction

endpackage

// File: rtl/fetch_tagq.sv
// DEPTH-entry FIFO of {tag, data} with combinational head/tail view,
// flush, and simultaneous push+pop (legal even when full).
module fetch_tagq #(
  parameter int AW    = 16,
  parameter int IW    = 32,
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  logic [AW-1:0] push_tag,
  input  logic [IW-1:0] push_data,
  output logic [AW-1:0] head_tag,
  output logic [IW-1:0] head_data,
  output logic [IW-1:0] tail_data,
  output logic          full,
  output logic          empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW-1:0] tag_mem  [DEPTH];
  logic [IW-1:0] data_mem [DEPTH];
  logic [PW-1:0] rd_ptr_reg, wr_ptr_reg, tail_ptr;
  logic [PW:0]   count_reg;
  logic          do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty    = (count_reg == '0);
  assign full     = (count_reg == (PW + 1)'(DEPTH));
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign tail_ptr = (wr_ptr_reg == '0) ? PW'(DEPTH - 1) : wr_ptr_reg - 1'b1;

  assign head_tag  = tag_mem[rd_ptr_reg];
  assign head_data = data_mem[rd_ptr_reg];
  assign tail_data = data_mem[tail_ptr];

  always_ff @(negedge clk) begin
    if (do_push && !flush && !rst) begin
      tag_mem[wr_ptr_reg]  <= push_tag;
      data_mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(negedge clk) begin
    if (rst || flush) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (do_pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      count_reg <= count_reg + (PW + 1)'(do_push) - (PW + 1)'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_pq.sv
// Instruction fetch unit with a DEPTH-entry tagged prefetch queue.
// Optional FETCH_PERF_CNT_EN adds saturating hit/miss counters.
module fetch_pq #(
  parameter int AW    = 16,
  parameter int IW    = 32,
  parameter int DEPTH = 2,
  parameter int OPC_W = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flag_boot_mode,
  input  logic [AW-1:0] pc_in,
  output logic          pc_hold,
  output logic [IW-1:0] instr_out,
  output logic          ram_read,
  output logic [AW-1:0] ram_addr,
  output logic          ram_addr_ovr,
`ifdef FETCH_PERF_CNT_EN
  output logic [15:0]   perf_hit,
  output logic [15:0]   perf_miss,
`endif
  input  logic [IW-1:0] ram_data,
  input  logic          ram_busy,
  input  logic          ram_cack,
  input  logic          ram_data_ready
);

  import fetch_pkg::*;

  fetch_state_t  state_reg, state_next;
  logic [AW-1:0] prev_pc_reg, next_addr_reg, ram_addr_reg, issue_addr;
  logic [IW-1:0] instr_out_reg, newest;
  logic [7:0]    newest_opc;
  logic          ram_read_reg, ram_addr_ovr_reg, pc_hold_reg;
  logic          pc_change, req_done, hit, bypass, miss, pref_ok, issue_en;

  logic          q_push, q_pop, q_flush, q_full, q_empty;
  logic [AW-1:0] q_head_tag;
  logic [IW-1:0] q_head_data, q_tail_data;

  fetch_tagq #(.AW(AW), .IW(IW), .DEPTH(DEPTH)) u_tagq (
    .clk       (clk),
    .rst       (rst),
    .flush     (q_flush),
    .push      (q_push),
    .pop       (q_pop),
    .push_tag  (ram_addr_reg),
    .push_data (ram_data),
    .head_tag  (q_head_tag),
    .head_data (q_head_data),
    .tail_data (q_tail_data),
    .full      (q_full),
    .empty     (q_empty)
  );

  always_comb begin
    pc_change  = (pc_in != prev_pc_reg);
    req_done   = ram_data_ready && ram_addr_ovr_reg;
    hit        = pc_change && !q_empty && (q_head_tag == pc_in);
    bypass     = pc_change && !hit && q_empty && (state_reg == ST_PREF) &&
                 req_done && (ram_addr_reg == pc_in);
    miss       = pc_change && !hit && !bypass;
    // Newest known instruction decides whether straight-line prefetch is safe.
    newest     = q_empty ? instr_out_reg : q_tail_data;
    newest_opc = 8'(newest[OPC_W-1:0]);
    pref_ok    = !q_full && !pc_hold_reg && !ram_busy && !is_memop(newest_opc);

    q_flush = flag_boot_mode || miss;
    q_pop   = !flag_boot_mode && hit;
    q_push  = !flag_boot_mode && !miss && !bypass && (state_reg == ST_PREF) && req_done;
  end

  always_comb begin
    state_next = state_reg;
    issue_en   = 1'b0;
    issue_addr = pc_in;
    if (miss) begin
      // A read still in flight must drain before the demand can go out.
      if (ram_addr_ovr_reg && !ram_data_ready) begin
        state_next = ST_DISCARD;
      end else begin
        state_next = ST_DEMAND;
        issue_en   = !ram_busy;
      end
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (pref_ok) begin
            state_next = ST_PREF;
            issue_en   = 1'b1;
            issue_addr = next_addr_reg;
          end
        end
        ST_DEMAND: begin
          if (!ram_addr_ovr_reg)   issue_en   = !ram_busy;
          else if (ram_data_ready) state_next = ST_IDLE;
        end
        ST_PREF: begin
          if (req_done) state_next = ST_IDLE;
        end
        ST_DISCARD: begin
          if (req_done) begin
            if (pc_hold_reg) begin
              state_next = ST_DEMAND;
              issue_en   = !ram_busy;
            end else begin
              state_next = ST_IDLE;
            end
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(negedge clk) begin
    if (rst) begin
      state_reg        <= ST_IDLE;
      prev_pc_reg      <= '1;
      next_addr_reg    <= '0;
      ram_addr_reg     <= '0;
      ram_read_reg     <= 1'b0;
      ram_addr_ovr_reg <= 1'b0;
      pc_hold_reg      <= 1'b0;
      instr_out_reg    <= '0;
    end else if (flag_boot_mode) begin
      state_reg        <= ST_IDLE;
      prev_pc_reg      <= '1;
      ram_addr_reg     <= '0;
      ram_read_reg     <= 1'b0;
      ram_addr_ovr_reg <= 1'b0;
      pc_hold_reg      <= 1'b0;
      instr_out_reg    <= '0;
    end else begin
      state_reg   <= state_next;
      prev_pc_reg <= pc_in;

      if (issue_en) begin
        ram_read_reg     <= 1'b1;
        ram_addr_ovr_reg <= 1'b1;
        ram_addr_reg     <= issue_addr;
      end else begin
        if (ram_cack) ram_read_reg     <= 1'b0;
        if (req_done) ram_addr_ovr_reg <= 1'b0;
      end

      if (miss) begin
        instr_out_reg <= '0;
        pc_hold_reg   <= 1'b1;
      end else if (hit) begin
        instr_out_reg <= q_head_data;
      end else if (bypass) begin
        instr_out_reg <= ram_data;
      end else if ((state_reg == ST_DEMAND) && req_done) begin
        instr_out_reg <= ram_data;
        pc_hold_reg   <= 1'b0;
      end

      if (!miss && req_done && ((state_reg == ST_DEMAND) || (state_reg == ST_PREF)))
        next_addr_reg <= ram_addr_reg + 1'b1;
    end
  end

  assign pc_hold      = pc_hold_reg;
  assign instr_out    = instr_out_reg;
  assign ram_read     = ram_read_reg;
  assign ram_addr     = ram_addr_reg;
  assign ram_addr_ovr = ram_addr_ovr_reg;

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] perf_hit_reg, perf_miss_reg;

  always_ff @(negedge clk) begin
    if (rst) begin
      perf_hit_reg  <= '0;
      perf_miss_reg <= '0;
    end else if (!flag_boot_mode) begin
      if ((hit || bypass) && (perf_hit_reg != 16'hFFFF)) perf_hit_reg <= perf_hit_reg + 1'b1;
      if (miss && (perf_miss_reg != 16'hFFFF))           perf_miss_reg <= perf_miss_reg + 1'b1;
    end
  end

  assign perf_hit  = perf_hit_reg;
  assign perf_miss = perf_miss_reg;
`endif

endmodule
